// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn sequencer: arbitrates the player commit requests, debounces them,
// and issues a single one-hot write strobe per accepted move. It also tracks the turn,
// the move count, the error indicator and the game-over state.
module ttt_turn_controller #(
  parameter int unsigned DEB_CYCLES   = 16,
  parameter int unsigned ERR_HOLD     = 50,
  parameter int unsigned FIRST_PLAYER = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_p1_req,
  input  logic       i_p2_req,
  input  logic [3:0] i_pos_sel,
  input  logic       i_new_game,
  input  logic       i_ill_move,
  input  logic       i_no_space,
  input  logic       i_win,
  output logic [8:0] o_p1_en,
  output logic [8:0] o_p2_en,
  output logic [1:0] o_turn,
  output logic [3:0] o_move_cnt,
  output logic       o_err_flag,
  output logic       o_game_over
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned ERR_W = $clog2(ERR_HOLD + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_LOAD = ERR_W'(ERR_HOLD);
  localparam logic [1:0]       TURN_P1    = 2'b01;
  localparam logic [1:0]       TURN_P2    = 2'b10;
  localparam logic [1:0]       TURN_NONE  = 2'b00;
  localparam logic [1:0]       TURN_FIRST = (FIRST_PLAYER == 2) ? TURN_P2 : TURN_P1;
  localparam logic [3:0]       POS_MAX    = 4'd8;
  localparam logic [3:0]       MOVES_MAX  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_WRITE,
    S_CHECK,
    S_ERROR,
    S_RELEASE,
    S_GAME_OVER
  } state_t;

  state_t           r_state;
  logic [3:0]       r_pos;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic [1:0]       r_turn;
  logic [3:0]       r_move_cnt;
  logic             r_err_flag;
  logic             r_game_over;
  logic [8:0]       r_p1_en;
  logic [8:0]       r_p2_en;

  state_t           w_state_nxt;
  logic [3:0]       w_pos_nxt;
  logic [DEB_W-1:0] w_deb_nxt;
  logic [ERR_W-1:0] w_err_cnt_nxt;
  logic [1:0]       w_turn_nxt;
  logic [3:0]       w_move_cnt_nxt;
  logic             w_err_flag_nxt;
  logic             w_game_over_nxt;
  logic [8:0]       w_p1_en_nxt;
  logic [8:0]       w_p2_en_nxt;
  logic             w_reject;
  logic             w_turn_req;
  logic             w_other_req;
  logic             w_stable;
  logic [8:0]       w_onehot;

  // Split the request lines into the player on turn and the one waiting
  always_comb begin
    w_turn_req  = 1'b0;
    w_other_req = 1'b0;
    if (r_turn == TURN_P1) begin
      w_turn_req  = i_p1_req;
      w_other_req = i_p2_req;
    end else if (r_turn == TURN_P2) begin
      w_turn_req  = i_p2_req;
      w_other_req = i_p1_req;
    end
    w_stable = w_turn_req & ~w_other_req & (i_pos_sel == r_pos);
    w_onehot = 9'(9'd1 << r_pos);
  end

  // Next-state and next-output logic of the sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_pos_nxt       = r_pos;
    w_deb_nxt       = r_deb_cnt;
    w_turn_nxt      = r_turn;
    w_move_cnt_nxt  = r_move_cnt;
    w_game_over_nxt = r_game_over;
    w_reject        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_deb_nxt = '0;
        if (w_turn_req && !w_other_req) begin
          w_pos_nxt   = i_pos_sel;
          w_state_nxt = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!w_stable) begin
          w_deb_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_deb_nxt = '0;
          if (r_pos > POS_MAX) begin
            w_reject    = 1'b1;
            w_state_nxt = S_ERROR;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end else begin
          w_deb_nxt = r_deb_cnt + DEB_W'(1);
        end
      end
      S_WRITE: begin
        // The position bank drops the write itself when the cell is occupied
        if (i_ill_move) begin
          w_reject    = 1'b1;
          w_state_nxt = S_ERROR;
        end else begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_move_cnt_nxt = (r_move_cnt == MOVES_MAX) ? MOVES_MAX : r_move_cnt + 4'd1;
        if (i_win || i_no_space) begin
          w_turn_nxt      = TURN_NONE;
          w_game_over_nxt = 1'b1;
          w_state_nxt     = S_GAME_OVER;
        end else begin
          w_turn_nxt  = r_turn ^ 2'b11;
          w_state_nxt = S_RELEASE;
        end
      end
      S_ERROR: begin
        w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        // A held switch must be let go before it can commit again
        if (!i_p1_req && !i_p2_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GAME_OVER: begin
        if (i_new_game) begin
          w_move_cnt_nxt  = '0;
          w_turn_nxt      = TURN_FIRST;
          w_game_over_nxt = 1'b0;
          w_state_nxt     = S_RELEASE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Strobe is driven during the WRITE cycle so the detector can judge it
    w_p1_en_nxt = '0;
    w_p2_en_nxt = '0;
    if (w_state_nxt == S_WRITE) begin
      if (r_turn == TURN_P1) begin
        w_p1_en_nxt = w_onehot;
      end else if (r_turn == TURN_P2) begin
        w_p2_en_nxt = w_onehot;
      end
    end

    // Error indicator hold timer; every rejection restarts it
    w_err_cnt_nxt  = r_err_cnt;
    w_err_flag_nxt = 1'b0;
    if (w_reject) begin
      w_err_cnt_nxt  = ERR_LOAD;
      w_err_flag_nxt = 1'b1;
    end else if (r_err_cnt != '0) begin
      w_err_cnt_nxt  = r_err_cnt - ERR_W'(1);
      w_err_flag_nxt = (r_err_cnt > ERR_W'(1));
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pos       <= '0;
      r_deb_cnt   <= '0;
      r_err_cnt   <= '0;
      r_turn      <= TURN_FIRST;
      r_move_cnt  <= '0;
      r_err_flag  <= 1'b0;
      r_game_over <= 1'b0;
      r_p1_en     <= '0;
      r_p2_en     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pos       <= w_pos_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_turn      <= w_turn_nxt;
      r_move_cnt  <= w_move_cnt_nxt;
      r_err_flag  <= w_err_flag_nxt;
      r_game_over <= w_game_over_nxt;
      r_p1_en     <= w_p1_en_nxt;
      r_p2_en     <= w_p2_en_nxt;
    end
  end

  assign o_p1_en     = r_p1_en;
  assign o_p2_en     = r_p2_en;
  assign o_turn      = r_turn;
  assign o_move_cnt  = r_move_cnt;
  assign o_err_flag  = r_err_flag;
  assign o_game_over = r_game_over;

endmodule
